gpregs_mp: RTL and testbench

Parametrised multi-port general-purpose register file: the next-generation register file for the MR core. It generalises width, depth and port counts, and adds three things:

- same-cycle write-to-read bypass;
- a per-register pending-write scoreboard for issue interlocks;
- a post-reset zero-initialisation sweep.

It sits between decode (read/lock) and writeback (write/unlock).

---
 rtl/gpregs_mp_if.sv | 38 +++
 rtl/gpregs_mp.sv | 151 +++++++++++++++
 tb/tb_gpregs_mp.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpregs_mp_if.sv
// Register-file bus for gpregs_mp.
// Groups the decode-side (read/lock) and writeback-side (write) signals of the register file.
//   write_en/write_select/write_val : NWRITE synchronous write ports, packed per port
//   read_select/read_val            : NREAD combinational read ports, packed per port
//   read_pending                    : per read port, selected register has an outstanding lock
//   lock_en/lock_select             : mark one register pending
//   ready                           : low while the post-reset zero sweep runs
//   conflict                        : one-cycle pulse after two write ports hit the same register
// master drives requests (decode/writeback side); slave is the register file.
interface gpregs_mp_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 3,
  parameter int unsigned NWRITE = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NWRITE-1:0]       write_en;
  logic [NWRITE*AW-1:0]    write_select;
  logic [NWRITE*WIDTH-1:0] write_val;
  logic [NREAD*AW-1:0]     read_select;
  logic [NREAD*WIDTH-1:0]  read_val;
  logic [NREAD-1:0]        read_pending;
  logic                    lock_en;
  logic [AW-1:0]           lock_select;
  logic                    ready;
  logic                    conflict;

  modport master (
    output write_en, write_select, write_val, read_select, lock_en, lock_select,
    input  read_val, read_pending, ready, conflict
  );

  modport slave (
    input  write_en, write_select, write_val, read_select, lock_en, lock_select,
    output read_val, read_pending, ready, conflict
  );
endinterface

// File: rtl/gpregs_mp.sv
// Multi-port general-purpose register file with write-to-read bypass, a per-register
// pending-write scoreboard and a zero-initialisation sweep after reset.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; restarts the zero sweep
//   bus   : gpregs_mp_if slave (write ports, read ports, lock port, ready, conflict)
// Parameters: WIDTH bits per register, DEPTH registers (power of two, >= 2), NREAD read
// ports, NWRITE write ports, BYPASS (1 = same-cycle write data forwarded to reads).
// On any same-register collision the lowest-numbered write port wins.
module gpregs_mp #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NREAD  = 3,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic       clk,
  input  logic       reset,
  gpregs_mp_if.slave bus
);
  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] SweepLast = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    sweep_q, sweep_d;
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             conflict_q, conflict_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]          wsel [NWRITE];
  logic [WIDTH-1:0]       wval [NWRITE];
  logic [AW-1:0]          rsel [NREAD];
  logic [WIDTH-1:0]       rmux [NREAD];
  logic [NREAD*WIDTH-1:0] read_val_flat;
  logic [NREAD-1:0]       read_pending_flat;
  logic [DEPTH-1:0]       reg_we;
  logic [WIDTH-1:0]       reg_wd [DEPTH];
  logic                   run;

  for (genvar p = 0; p < NWRITE; p++) begin : g_wport
    assign wsel[p] = bus.write_select[p*AW +: AW];
    assign wval[p] = bus.write_val[p*WIDTH +: WIDTH];
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rport
    assign rsel[r] = bus.read_select[r*AW +: AW];
  end

  assign run              = (state_q == StRun);
  assign bus.ready        = run;
  assign bus.conflict     = conflict_q;
  assign bus.read_val     = read_val_flat;
  assign bus.read_pending = read_pending_flat;

  // Init/run sequencing: the sweep counter walks every index once, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == SweepLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Per-register write decode, collision detect and scoreboard update.
  always_comb begin
    reg_we     = '0;
    reg_wd     = '{default: '0};
    conflict_d = 1'b0;
    pending_d  = pending_q;
    if (run) begin
      // Walk ports from the top down so a lower-numbered port overrides on a collision.
      for (int p = int'(NWRITE) - 1; p >= 0; p--) begin
        if (bus.write_en[p]) begin
          reg_we[wsel[p]]    = 1'b1;
          reg_wd[wsel[p]]    = wval[p];
          pending_d[wsel[p]] = 1'b0;
        end
      end
      for (int p = 0; p < int'(NWRITE); p++) begin
        for (int q = p + 1; q < int'(NWRITE); q++) begin
          if (bus.write_en[p] && bus.write_en[q] && (wsel[p] == wsel[q])) begin
            conflict_d = 1'b1;
          end
        end
      end
      // Applied after the clears so a same-cycle lock keeps the bit set.
      if (bus.lock_en) begin
        pending_d[bus.lock_select] = 1'b1;
      end
    end else begin
      reg_we[sweep_q] = 1'b1;
    end
  end

  // Read ports: storage, optionally overridden by same-cycle write data, gated off in INIT.
  // The pending bit is deliberately not bypassed.
  always_comb begin
    rmux              = '{default: '0};
    read_val_flat     = '0;
    read_pending_flat = '0;
    for (int r = 0; r < int'(NREAD); r++) begin
      rmux[r] = mem_q[rsel[r]];
      if (BYPASS != 0) begin
        for (int p = int'(NWRITE) - 1; p >= 0; p--) begin
          if (bus.write_en[p] && (wsel[p] == rsel[r])) begin
            rmux[r] = wval[p];
          end
        end
      end
      if (run) begin
        read_val_flat[r*WIDTH +: WIDTH] = rmux[r];
        read_pending_flat[r]            = pending_q[rsel[r]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      pending_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      pending_q  <= pending_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage has no reset; the sweep rewrites every entry before reads are enabled.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (reg_we[i]) begin
        mem_q[i] <= reg_wd[i];
      end
    end
  end
endmodule

// File: tb/tb_gpregs_mp.sv
// Bench for gpregs_mp: instance a (defaults, BYPASS=1) and instance b (64x16, 4R/3W, BYPASS=0)
// share clock and reset. A behavioural model of both is checked every cycle, alongside
// hand-computed literal expectations driven by directed vectors.
module tb_gpregs_mp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gpregs_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(3), .NWRITE(2)) if_a ();
  gpregs_mp_if #(.WIDTH(64), .DEPTH(16), .NREAD(4), .NWRITE(3)) if_b ();

  gpregs_mp #(.WIDTH(32), .DEPTH(32), .NREAD(3), .NWRITE(2), .BYPASS(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  gpregs_mp #(.WIDTH(64), .DEPTH(16), .NREAD(4), .NWRITE(3), .BYPASS(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  // Stimulus, indexed [instance][port]
  logic        t_wen  [2][3];
  logic [4:0]  t_wsel [2][3];
  logic [63:0] t_wval [2][3];
  logic [4:0]  t_rsel [2][4];
  logic        t_lock [2];
  logic [4:0]  t_lsel [2];

  always_comb begin
    if_a.write_en = '0;
    if_a.write_select = '0;
    if_a.write_val = '0;
    if_a.read_select = '0;
    for (int p = 0; p < 2; p++) begin
      if_a.write_en[p] = t_wen[0][p];
      if_a.write_select[p*5 +: 5] = t_wsel[0][p];
      if_a.write_val[p*32 +: 32] = t_wval[0][p][31:0];
    end
    for (int r = 0; r < 3; r++) if_a.read_select[r*5 +: 5] = t_rsel[0][r];
    if_a.lock_en = t_lock[0];
    if_a.lock_select = t_lsel[0];
  end

  always_comb begin
    if_b.write_en = '0;
    if_b.write_select = '0;
    if_b.write_val = '0;
    if_b.read_select = '0;
    for (int p = 0; p < 3; p++) begin
      if_b.write_en[p] = t_wen[1][p];
      if_b.write_select[p*4 +: 4] = t_wsel[1][p][3:0];
      if_b.write_val[p*64 +: 64] = t_wval[1][p];
    end
    for (int r = 0; r < 4; r++) if_b.read_select[r*4 +: 4] = t_rsel[1][r][3:0];
    if_b.lock_en = t_lock[1];
    if_b.lock_select = t_lsel[1][3:0];
  end

  // Instance geometry
  function automatic int dep(int i); return (i == 0) ? 32 : 16; endfunction
  function automatic int nr(int i); return (i == 0) ? 3 : 4; endfunction
  function automatic int nw(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic bit byp(int i); return (i == 0); endfunction
  function automatic logic [63:0] msk(int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction
  function automatic int ws(int i, int p); return int'(t_wsel[i][p]) % dep(i); endfunction
  function automatic int rs(int i, int r); return int'(t_rsel[i][r]) % dep(i); endfunction
  function automatic int ls(int i); return int'(t_lsel[i]) % dep(i); endfunction

  // DUT observation
  function automatic logic [63:0] dut_rv(int i, int r);
    if (i == 0) return {32'h0, if_a.read_val[r*32 +: 32]};
    return if_b.read_val[r*64 +: 64];
  endfunction
  function automatic logic dut_rp(int i, int r);
    return (i == 0) ? if_a.read_pending[r] : if_b.read_pending[r];
  endfunction
  function automatic logic dut_ready(int i); return (i == 0) ? if_a.ready : if_b.ready; endfunction
  function automatic logic dut_conf(int i);
    return (i == 0) ? if_a.conflict : if_b.conflict;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, lock bits, sweep cycles left, conflict pulse.
  logic [63:0] m_mem  [2][32];
  logic        m_pend [2][32];
  int          m_left [2];
  logic        m_conf [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = dep(i);
      m_conf[i] = 1'b0;
      for (int k = 0; k < 32; k++) begin
        m_mem[i][k]  = '0;
        m_pend[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    logic c;
    logic beaten;
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] > 0) begin
        m_left[i]--;
        m_conf[i] = 1'b0;
      end else begin
        c = 1'b0;
        for (int p = 0; p < nw(i); p++)
          for (int q = p + 1; q < nw(i); q++)
            if (t_wen[i][p] && t_wen[i][q] && ws(i, p) == ws(i, q)) c = 1'b1;
        for (int p = 0; p < nw(i); p++) begin
          if (t_wen[i][p]) begin
            beaten = 1'b0;
            for (int q = 0; q < p; q++)
              if (t_wen[i][q] && ws(i, q) == ws(i, p)) beaten = 1'b1;
            if (!beaten) m_mem[i][ws(i, p)] = t_wval[i][p] & msk(i);
            m_pend[i][ws(i, p)] = 1'b0;
          end
        end
        if (t_lock[i]) m_pend[i][ls(i)] = 1'b1;
        m_conf[i] = c;
      end
    end
  endtask

  function automatic logic [63:0] exp_rv(int i, int r);
    if (!reset || m_left[i] != 0) return '0;
    if (byp(i))
      for (int p = 0; p < nw(i); p++)
        if (t_wen[i][p] && ws(i, p) == rs(i, r)) return t_wval[i][p] & msk(i);
    return m_mem[i][rs(i, r)];
  endfunction

  function automatic logic exp_rp(int i, int r);
    if (!reset || m_left[i] != 0) return 1'b0;
    return m_pend[i][rs(i, r)];
  endfunction

  // Compare process: outputs are checked mid-low-phase, model advances on each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) model_reset();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s_ready", i == 0 ? "a" : "b"), 64'(dut_ready(i)),
            64'(reset && m_left[i] == 0));
        chk($sformatf("%s_conflict", i == 0 ? "a" : "b"), 64'(dut_conf(i)), 64'(m_conf[i]));
        for (int r = 0; r < nr(i); r++) begin
          chk($sformatf("%s_read_val%0d", i == 0 ? "a" : "b", r), dut_rv(i, r), exp_rv(i, r));
          chk($sformatf("%s_read_pending%0d", i == 0 ? "a" : "b", r), 64'(dut_rp(i, r)),
              64'(exp_rp(i, r)));
        end
      end
      @(posedge clk);
      if (reset) model_step();
    end
  end

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      t_lock[i] = 1'b0;
      t_lsel[i] = '0;
      for (int p = 0; p < 3; p++) begin
        t_wen[i][p]  = 1'b0;
        t_wsel[i][p] = '0;
        t_wval[i][p] = '0;
      end
    end
  endtask

  // Counts falling edges after reset release until each instance reports ready.
  task automatic measure_init(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #3;
      if (k == 5) chk("init_read_forced_zero", dut_rv(0, 0), 64'h0);
      if (nb == 0 && if_b.ready) begin
        nb = k;
        t_wen[1][1] = 1'b0;
        t_lock[1] = 1'b0;
      end
      if (na == 0 && if_a.ready) na = k;
      if (na != 0) break;
    end
    idle();
  endtask

  initial begin
    int na, nb;
    idle();
    for (int i = 0; i < 2; i++) for (int r = 0; r < 4; r++) t_rsel[i][r] = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    // Writes and locks attempted during the sweep must have no effect.
    t_wen[0][0] = 1'b1; t_wsel[0][0] = 5'd2; t_wval[0][0] = 64'hFFFF_FFFF;
    t_lock[0] = 1'b1; t_lsel[0] = 5'd2; t_rsel[0][0] = 5'd2;
    t_wen[1][1] = 1'b1; t_wsel[1][1] = 5'd2; t_wval[1][1] = '1;
    t_lock[1] = 1'b1; t_lsel[1] = 5'd2; t_rsel[1][0] = 5'd2;
    reset = 1'b1;
    measure_init(na, nb);
    chk("init_cycles_a", 64'(na), 64'd32);
    chk("init_cycles_b", 64'(nb), 64'd16);
    @(negedge clk); #3;
    chk("init_write_ignored", dut_rv(0, 0), 64'h0);
    chk("init_lock_ignored", 64'(dut_rp(0, 0)), 64'h0);

    // Two-port write, read back next cycle
    @(negedge clk);
    t_wen[0][0] = 1'b1; t_wsel[0][0] = 5'd5;  t_wval[0][0] = 64'hDEAD_BEEF;
    t_wen[0][1] = 1'b1; t_wsel[0][1] = 5'd31; t_wval[0][1] = 64'h1234_5678;
    t_rsel[0][0] = 5'd5; t_rsel[0][1] = 5'd31; t_rsel[0][2] = 5'd0;
    @(negedge clk); idle(); #3;
    chk("wr_rd_port0", dut_rv(0, 0), 64'hDEAD_BEEF);
    chk("wr_rd_port1", dut_rv(0, 1), 64'h1234_5678);
    chk("wr_rd_port2", dut_rv(0, 2), 64'h0);

    // Bypass on a, none on b
    @(negedge clk);
    t_wen[1][0] = 1'b1; t_wsel[1][0] = 5'd7; t_wval[1][0] = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    t_wen[0][0] = 1'b1; t_wsel[0][0] = 5'd7; t_wval[0][0] = 64'hA5A5_A5A5;
    t_rsel[0][0] = 5'd7;
    t_wen[1][0] = 1'b1; t_wsel[1][0] = 5'd7; t_wval[1][0] = 64'hA5A5_A5A5_5A5A_5A5A;
    t_rsel[1][0] = 5'd7;
    #3;
    chk("bypass_same_cycle", dut_rv(0, 0), 64'hA5A5_A5A5);
    chk("nobypass_old_value", dut_rv(1, 0), 64'h0123_4567_89AB_CDEF);
    @(negedge clk); idle(); #3;
    chk("nobypass_new_value", dut_rv(1, 0), 64'hA5A5_A5A5_5A5A_5A5A);

    // Same-register collision, held for two cycles on b
    @(negedge clk);
    t_wen[0][0] = 1'b1; t_wsel[0][0] = 5'd3; t_wval[0][0] = 64'h1111;
    t_wen[0][1] = 1'b1; t_wsel[0][1] = 5'd3; t_wval[0][1] = 64'h2222;
    t_rsel[0][0] = 5'd3;
    t_wen[1][0] = 1'b1; t_wsel[1][0] = 5'd3; t_wval[1][0] = 64'hAAAA;
    t_wen[1][1] = 1'b1; t_wsel[1][1] = 5'd4; t_wval[1][1] = 64'hBBBB;
    t_wen[1][2] = 1'b1; t_wsel[1][2] = 5'd3; t_wval[1][2] = 64'hCCCC;
    t_rsel[1][0] = 5'd3; t_rsel[1][1] = 5'd4;
    @(negedge clk);
    t_wen[0][0] = 1'b0; t_wen[0][1] = 1'b0;
    #3;
    chk("conflict_a_pulse", 64'(if_a.conflict), 64'h1);
    chk("conflict_a_winner", dut_rv(0, 0), 64'h1111);
    chk("conflict_b_pulse", 64'(if_b.conflict), 64'h1);
    @(negedge clk); idle(); #3;
    chk("conflict_a_cleared", 64'(if_a.conflict), 64'h0);
    chk("conflict_b_held", 64'(if_b.conflict), 64'h1);
    chk("conflict_b_winner", dut_rv(1, 0), 64'hAAAA);
    chk("conflict_b_other", dut_rv(1, 1), 64'hBBBB);
    @(negedge clk); #3;
    chk("conflict_b_cleared", 64'(if_b.conflict), 64'h0);

    // Scoreboard on a
    t_rsel[0][0] = 5'd9;
    @(negedge clk); t_lock[0] = 1'b1; t_lsel[0] = 5'd9;
    @(negedge clk); idle(); #3;
    chk("lock_sets_pending", 64'(if_a.read_pending[0]), 64'h1);
    @(negedge clk);
    t_wen[0][0] = 1'b1; t_wsel[0][0] = 5'd9; t_wval[0][0] = 64'h99;
    #3;
    chk("pending_not_bypassed", 64'(if_a.read_pending[0]), 64'h1);
    @(negedge clk); idle(); #3;
    chk("write_clears_pending", 64'(if_a.read_pending[0]), 64'h0);
    @(negedge clk);
    t_lock[0] = 1'b1; t_lsel[0] = 5'd9;
    t_wen[0][1] = 1'b1; t_wsel[0][1] = 5'd9; t_wval[0][1] = 64'h77;
    @(negedge clk); idle(); #3;
    chk("lock_beats_write", 64'(if_a.read_pending[0]), 64'h1);
    chk("lock_write_value", dut_rv(0, 0), 64'h77);

    // All ports of b independently
    @(negedge clk);
    t_wen[1][0] = 1'b1; t_wsel[1][0] = 5'd10; t_wval[1][0] = 64'h1000_0000_0000_000A;
    t_wen[1][1] = 1'b1; t_wsel[1][1] = 5'd11; t_wval[1][1] = 64'h2000_0000_0000_000B;
    t_wen[1][2] = 1'b1; t_wsel[1][2] = 5'd12; t_wval[1][2] = 64'h3000_0000_0000_000C;
    t_lock[1] = 1'b1; t_lsel[1] = 5'd13;
    t_rsel[1][0] = 5'd10; t_rsel[1][1] = 5'd11; t_rsel[1][2] = 5'd12; t_rsel[1][3] = 5'd13;
    @(negedge clk); idle(); #3;
    chk("b_port0", dut_rv(1, 0), 64'h1000_0000_0000_000A);
    chk("b_port1", dut_rv(1, 1), 64'h2000_0000_0000_000B);
    chk("b_port2", dut_rv(1, 2), 64'h3000_0000_0000_000C);
    chk("b_pending3", 64'(if_b.read_pending[3]), 64'h1);

    // Reset in RUN, then reset part-way through the sweep
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_run_ready", 64'(if_a.ready), 64'h0);
    chk("reset_run_pending", 64'(if_a.read_pending[0]), 64'h0);
    chk("reset_run_read", dut_rv(0, 0), 64'h0);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_sweep_ready", 64'(if_a.ready), 64'h0);
    @(negedge clk); reset = 1'b1;
    measure_init(na, nb);
    chk("resweep_cycles_a", 64'(na), 64'd32);
    chk("resweep_cycles_b", 64'(nb), 64'd16);
    @(negedge clk); #3;
    chk("resweep_zeroed", dut_rv(0, 0), 64'h0);
    chk("resweep_pending", 64'(if_b.read_pending[3]), 64'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
